// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command framing controller.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
  localparam int unsigned MAX_LEN_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_COMMIT
  } state_t;

  // Width of a counter that must hold 0..max_len inclusive.
  function automatic int unsigned idx_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width of a register-file address for max_len entries (at least 1 bit).
  function automatic int unsigned buf_addr_width(input int unsigned max_len);
    return (max_len < 2) ? 1 : $clog2(max_len);
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Register-write port between the framing controller and the bus bridge.
interface uart_cmd_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] oWrAddr;
  logic [7:0]        oWrData;
  logic              oWrValid;
  logic              iWrReady;

  modport master (
    output oWrAddr,
    output oWrData,
    output oWrValid,
    input  iWrReady
  );

  modport slave (
    input  oWrAddr,
    input  oWrData,
    input  oWrValid,
    output iWrReady
  );
endinterface

// File: rtl/uart_cmd_ctrl_buf.sv
// Payload buffer: DEPTH x 8 register file, one write port, one async read port.
module uart_cmd_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  localparam int unsigned MEM_D = (DEPTH < 2) ? 2 : DEPTH;

  logic [7:0] r_mem [MEM_D];

  // Store payload bytes; contents need no reset since they are only read after being written.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framing controller: parses SYNC ADDR LEN DATA[LEN] CSUM from the UART byte
// stream, buffers the payload and replays it as register writes once the
// checksum has passed.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 10000000,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic [7:0]       iData,
  input  logic             iValid,
  uart_cmd_ctrl_if.master  wr,
  output logic             oBusy,
  output logic             oErrCsum,
  output logic             oErrLen,
  output logic             oErrTimeout,
  output logic             oErrOverrun
);

  localparam int unsigned IW  = idx_width(MAX_LEN);
  localparam int unsigned BAW = buf_addr_width(MAX_LEN);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

  if (CLK_FREQ == 0 || TIMEOUT_CYCLES < 1 || MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_param
    $error("uart_cmd_ctrl: illegal parameter value");
  end

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [IW-1:0]     r_len;
  logic [IW-1:0]     r_idx;
  logic [7:0]        r_sum;
  logic [TW-1:0]     r_tmo;
  logic              r_err_len;
  logic              r_err_csum;
  logic              r_err_tmo;
  logic              r_err_ovr;

  logic [IW-1:0]     w_idx_inc;
  logic [7:0]        w_sum_next;
  logic              w_len_ok;
  logic              w_csum_ok;
  logic              w_tmo_exp;
  logic              w_err_len;
  logic              w_err_csum;
  logic              w_err_tmo;
  logic              w_err_ovr;
  logic              w_buf_we;
  logic [7:0]        w_buf_rdata;

  assign w_idx_inc  = r_idx + 1'b1;
  assign w_sum_next = r_sum + iData;
  assign w_len_ok   = (iData != 8'h00) && (32'(iData) <= MAX_LEN);
  assign w_csum_ok  = (w_sum_next == 8'h00);
  assign w_tmo_exp  = (r_tmo <= TW'(1));
  assign w_buf_we   = (r_state == ST_DATA) && iValid;

  uart_cmd_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BAW)
  ) u_buf (
    .i_clk   (iClk),
    .i_we    (w_buf_we),
    .i_waddr (r_idx[BAW-1:0]),
    .i_wdata (iData),
    .i_raddr (r_idx[BAW-1:0]),
    .o_rdata (w_buf_rdata)
  );

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and error-cause detection; a byte in the expiry cycle beats the timeout.
  always_comb begin
    w_next     = r_state;
    w_err_len  = 1'b0;
    w_err_csum = 1'b0;
    w_err_tmo  = 1'b0;
    w_err_ovr  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iValid && iData == SYNC_BYTE) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (iValid)         w_next = ST_LEN;
        else if (w_tmo_exp) begin w_next = ST_IDLE; w_err_tmo = 1'b1; end
      end
      ST_LEN: begin
        if (iValid) begin
          if (w_len_ok) w_next = ST_DATA;
          else begin w_next = ST_IDLE; w_err_len = 1'b1; end
        end else if (w_tmo_exp) begin
          w_next = ST_IDLE; w_err_tmo = 1'b1;
        end
      end
      ST_DATA: begin
        if (iValid) begin
          if (w_idx_inc == r_len) w_next = ST_CSUM;
        end else if (w_tmo_exp) begin
          w_next = ST_IDLE; w_err_tmo = 1'b1;
        end
      end
      ST_CSUM: begin
        if (iValid) begin
          if (w_csum_ok) w_next = ST_COMMIT;
          else begin w_next = ST_IDLE; w_err_csum = 1'b1; end
        end else if (w_tmo_exp) begin
          w_next = ST_IDLE; w_err_tmo = 1'b1;
        end
      end
      ST_COMMIT: begin
        w_err_ovr = iValid;
        if (iWrReadyAccepted()) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  function automatic logic iWrReadyAccepted();
    return wr.iWrReady && (w_idx_inc == r_len);
  endfunction

  // Datapath: base, length, running sum, index, timeout counter and registered error pulses.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_base     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_sum      <= '0;
      r_tmo      <= '0;
      r_err_len  <= 1'b0;
      r_err_csum <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_ovr  <= 1'b0;
    end else begin
      r_err_len  <= w_err_len;
      r_err_csum <= w_err_csum;
      r_err_tmo  <= w_err_tmo;
      r_err_ovr  <= w_err_ovr;
      unique case (r_state)
        ST_IDLE: begin
          if (iValid && iData == SYNC_BYTE) r_tmo <= TW'(TIMEOUT_CYCLES);
        end
        ST_ADDR, ST_LEN, ST_DATA, ST_CSUM: begin
          if (iValid) r_tmo <= TW'(TIMEOUT_CYCLES);
          else        r_tmo <= r_tmo - 1'b1;
          if (iValid) begin
            unique case (r_state)
              ST_ADDR: begin
                r_base <= ADDR_W'(iData);
                r_sum  <= iData;
              end
              ST_LEN: begin
                if (w_len_ok) begin
                  r_len <= IW'(iData);
                  r_sum <= w_sum_next;
                  r_idx <= '0;
                end
              end
              ST_DATA: begin
                r_sum <= w_sum_next;
                r_idx <= w_idx_inc;
              end
              default: begin
                if (w_csum_ok) r_idx <= '0;
              end
            endcase
          end
        end
        ST_COMMIT: begin
          if (wr.iWrReady) r_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

  // Output decode; the write bus reads zero outside COMMIT so reset drives every output low.
  always_comb begin
    oBusy       = (r_state != ST_IDLE);
    wr.oWrValid = (r_state == ST_COMMIT);
    wr.oWrAddr  = '0;
    wr.oWrData  = '0;
    if (r_state == ST_COMMIT) begin
      wr.oWrAddr = r_base + ADDR_W'(r_idx);
      wr.oWrData = w_buf_rdata;
    end
    oErrCsum    = r_err_csum;
    oErrLen     = r_err_len;
    oErrTimeout = r_err_tmo;
    oErrOverrun = r_err_ovr;
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int unsigned TMO  = 40;
  localparam int unsigned MAXL = 16;

  logic       iClk = 1'b0;
  logic       iRstN;
  logic [7:0] iData;
  logic       iValid;
  logic       oBusy, oErrCsum, oErrLen, oErrTimeout, oErrOverrun;

  always #5 iClk = ~iClk;

  uart_cmd_ctrl_if #(.ADDR_W(8)) wr_if ();

  uart_cmd_ctrl #(
    .CLK_FREQ       (10000000),
    .TIMEOUT_CYCLES (TMO),
    .MAX_LEN        (MAXL),
    .ADDR_W         (8)
  ) dut (
    .iClk        (iClk),
    .iRstN       (iRstN),
    .iData       (iData),
    .iValid      (iValid),
    .wr          (wr_if),
    .oBusy       (oBusy),
    .oErrCsum    (oErrCsum),
    .oErrLen     (oErrLen),
    .oErrTimeout (oErrTimeout),
    .oErrOverrun (oErrOverrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] got_wr[$];
  logic [15:0] exp_wr[$];
  int ec_len, ec_csum, ec_tmo, ec_ovr;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_addr, prev_data;

  // Monitor: collect accepted writes, count error pulses, check exclusivity and stall stability.
  always @(negedge iClk) begin
    if (iRstN === 1'b1) begin
      if (wr_if.oWrValid && wr_if.iWrReady) got_wr.push_back({wr_if.oWrAddr, wr_if.oWrData});
      if (oErrLen)     ec_len++;
      if (oErrCsum)    ec_csum++;
      if (oErrTimeout) ec_tmo++;
      if (oErrOverrun) ec_ovr++;
      if (oErrLen || oErrCsum || oErrTimeout || oErrOverrun) begin
        n_tests++;
        if ((int'(oErrLen) + int'(oErrCsum) + int'(oErrTimeout) + int'(oErrOverrun)) != 1) begin
          n_fail++;
          $display("FAIL err_exclusive: got %b%b%b%b expected one-hot", oErrLen, oErrCsum, oErrTimeout, oErrOverrun);
        end
      end
      if (prev_stall) begin
        n_tests++;
        if (!(wr_if.oWrValid === 1'b1 && wr_if.oWrAddr === prev_addr && wr_if.oWrData === prev_data)) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                   wr_if.oWrValid, wr_if.oWrAddr, wr_if.oWrData, prev_addr, prev_data);
        end
      end
      prev_stall = wr_if.oWrValid && !wr_if.iWrReady;
      prev_addr  = wr_if.oWrAddr;
      prev_data  = wr_if.oWrData;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns 0 ok, 1 length error, 2 checksum error; pushes expected writes for good frames.
  function automatic int model_frame(input logic [7:0] f[$]);
    logic [7:0] s;
    int len;
    len = int'(f[2]);
    if (len == 0 || len > MAXL) return 1;
    s = 8'h00;
    for (int i = 1; i < f.size(); i++) s += f[i];
    if (s != 8'h00) return 2;
    for (int i = 0; i < len; i++) exp_wr.push_back({8'(int'(f[1]) + i), f[3+i]});
    return 0;
  endfunction

  task automatic build_frame(input logic [7:0] addr, input int len, input bit corrupt,
                             output logic [7:0] f[$]);
    logic [7:0] s;
    f = {8'hA5, addr, 8'(len)};
    if (len >= 1 && len <= MAXL) begin
      s = addr + 8'(len);
      for (int i = 0; i < len; i++) begin
        f.push_back(8'($urandom_range(0, 255)));
        s += f[f.size()-1];
      end
      s = 8'h00 - s;
      if (corrupt) s ^= 8'($urandom_range(1, 255));
      f.push_back(s);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic clear_mon();
    got_wr.delete();
    exp_wr.delete();
    ec_len = 0; ec_csum = 0; ec_tmo = 0; ec_ovr = 0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    for (int i = 0; i < q.size(); i++) begin
      iData  = q[i];
      iValid = 1'b1;
      tick();
    end
    iValid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (oBusy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: got busy=%b after %0d cycles expected 0", oBusy, budget);
    end
  endtask

  task automatic check_writes(input string name);
    n_tests++;
    if (got_wr.size() != exp_wr.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes expected %0d", name, got_wr.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        n_tests++;
        if (got_wr[i] !== exp_wr[i]) begin
          n_fail++;
          $display("FAIL %s_wr%0d: got addr/data %h expected %h", name, i, got_wr[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic check_errs(input string name, input int el, input int ec, input int et, input int eo);
    n_tests++;
    if (ec_len != el || ec_csum != ec || ec_tmo != et || ec_ovr != eo) begin
      n_fail++;
      $display("FAIL %s_errs: got len/csum/tmo/ovr %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
               name, ec_len, ec_csum, ec_tmo, ec_ovr, el, ec, et, eo);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [20:0] obs;
    obs = {oBusy, wr_if.oWrValid, wr_if.oWrAddr, wr_if.oWrData, oErrCsum, oErrLen, oErrTimeout, oErrOverrun};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL %s: got outputs %h expected 0", name, obs);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    iRstN = 1'b0; iValid = 1'b0; iData = 8'h00; wr_if.iWrReady = 1'b1;
    tick(); tick();
    check_all_zero("reset_outputs");
    iRstN = 1'b1;
    tick();
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_good_frame();
    clear_mon();
    wr_if.iWrReady = 1'b1;
    send_bytes({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB});
    n_tests++;
    if (!(wr_if.oWrValid === 1'b1 && wr_if.oWrAddr === 8'h10 && wr_if.oWrData === 8'h11)) begin
      n_fail++;
      $display("FAIL good_first: got v=%b a=%h d=%h expected v=1 a=10 d=11", wr_if.oWrValid, wr_if.oWrAddr, wr_if.oWrData);
    end
    tick();
    n_tests++;
    if (!(wr_if.oWrValid === 1'b1 && wr_if.oWrAddr === 8'h11 && wr_if.oWrData === 8'h22)) begin
      n_fail++;
      $display("FAIL good_second: got v=%b a=%h d=%h expected v=1 a=11 d=22", wr_if.oWrValid, wr_if.oWrAddr, wr_if.oWrData);
    end
    tick();
    n_tests++;
    if (!(wr_if.oWrValid === 1'b0 && oBusy === 1'b0)) begin
      n_fail++;
      $display("FAIL good_done: got v=%b busy=%b expected 0/0", wr_if.oWrValid, oBusy);
    end
    exp_wr = {16'h1011, 16'h1122};
    check_writes("good");
    check_errs("good", 0, 0, 0, 0);
  endtask

  task automatic test_csum_err();
    clear_mon();
    send_bytes({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBC});
    n_tests++;
    if (!(oErrCsum === 1'b1 && oBusy === 1'b0 && wr_if.oWrValid === 1'b0)) begin
      n_fail++;
      $display("FAIL csum_pulse: got err=%b busy=%b v=%b expected 1/0/0", oErrCsum, oBusy, wr_if.oWrValid);
    end
    tick(); tick();
    check_writes("csum");
    check_errs("csum", 0, 1, 0, 0);
  endtask

  task automatic test_addr_wrap();
    logic [7:0] f[$];
    int kind;
    clear_mon();
    f = {8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFC};
    kind = model_frame(f);
    send_bytes(f);
    wait_idle(20);
    n_tests++;
    if (kind != 0 || exp_wr.size() != 2 || exp_wr[1] !== 16'h0002) begin
      n_fail++;
      $display("FAIL wrap_model: got kind=%0d expected 0 with wrapped address", kind);
    end
    check_writes("wrap");
    check_errs("wrap", 0, 0, 0, 0);
  endtask

  task automatic test_len_err();
    logic [7:0] f[$];
    clear_mon();
    send_bytes({8'hA5, 8'h10, 8'h00});
    n_tests++;
    if (!(oErrLen === 1'b1 && oBusy === 1'b0)) begin
      n_fail++;
      $display("FAIL len0_pulse: got err=%b busy=%b expected 1/0", oErrLen, oBusy);
    end
    tick();
    send_bytes({8'hA5, 8'h10, 8'h11});
    n_tests++;
    if (!(oErrLen === 1'b1 && oBusy === 1'b0)) begin
      n_fail++;
      $display("FAIL len17_pulse: got err=%b busy=%b expected 1/0", oErrLen, oBusy);
    end
    tick();
    build_frame(8'h40, int'(MAXL), 1'b0, f);
    void'(model_frame(f));
    send_bytes(f);
    wait_idle(40);
    check_writes("len_next");
    check_errs("len", 2, 0, 0, 0);
  endtask

  task automatic test_timeout();
    clear_mon();
    send_bytes({8'hA5, 8'h10});
    repeat (TMO - 1) tick();
    n_tests++;
    if (!(oBusy === 1'b1 && oErrTimeout === 1'b0)) begin
      n_fail++;
      $display("FAIL tmo_early: got busy=%b err=%b expected 1/0", oBusy, oErrTimeout);
    end
    tick();
    n_tests++;
    if (!(oBusy === 1'b0 && oErrTimeout === 1'b1)) begin
      n_fail++;
      $display("FAIL tmo_pulse: got busy=%b err=%b expected 0/1", oBusy, oErrTimeout);
    end
    tick();
    // Second frame: LEN byte lands exactly on the expiry cycle and must be parsed.
    send_bytes({8'hA5, 8'h10});
    repeat (TMO - 1) tick();
    send_bytes({8'h02});
    n_tests++;
    if (!(oBusy === 1'b1 && oErrTimeout === 1'b0)) begin
      n_fail++;
      $display("FAIL tmo_expiry_byte: got busy=%b err=%b expected 1/0", oBusy, oErrTimeout);
    end
    send_bytes({8'h01, 8'h02, 8'hEB});
    wait_idle(20);
    exp_wr = {16'h1001, 16'h1102};
    check_writes("tmo");
    check_errs("tmo", 0, 0, 1, 0);
  endtask

  task automatic test_overrun_stall();
    clear_mon();
    wr_if.iWrReady = 1'b0;
    send_bytes({8'hA5, 8'h20, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hAC});
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (!(wr_if.oWrValid === 1'b1 && wr_if.oWrAddr === 8'h20 && wr_if.oWrData === 8'hAA)) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b a=%h d=%h expected v=1 a=20 d=AA", k, wr_if.oWrValid, wr_if.oWrAddr, wr_if.oWrData);
      end
      if (k == 2) begin
        n_tests++;
        if (oErrOverrun !== 1'b1) begin
          n_fail++;
          $display("FAIL overrun_pulse: got %b expected 1", oErrOverrun);
        end
      end
      if (k == 1) begin
        iData = 8'hA5; iValid = 1'b1;
      end
      tick();
      iValid = 1'b0;
    end
    wr_if.iWrReady = 1'b1;
    wait_idle(20);
    repeat (3) tick();
    n_tests++;
    if (oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_not_parsed: got busy=%b expected 0", oBusy);
    end
    exp_wr = {16'h20AA, 16'h21BB, 16'h22CC};
    check_writes("overrun");
    check_errs("overrun", 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_commit();
    clear_mon();
    wr_if.iWrReady = 1'b0;
    send_bytes({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB});
    tick();
    n_tests++;
    if (wr_if.oWrValid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_commit: got v=%b expected 1", wr_if.oWrValid);
    end
    iRstN = 1'b0;
    #1;
    check_all_zero("rst_mid_commit");
    tick();
    iRstN = 1'b1;
    wr_if.iWrReady = 1'b1;
    tick(); tick();
    check_all_zero("rst_recover");
    check_writes("rst");
  endtask

  task automatic test_random();
    logic [7:0] f[$];
    logic [7:0] g;
    int len, kind, k;
    for (int n = 0; n < 25; n++) begin
      clear_mon();
      if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXL + 1, 255));
      else                            len = int'($urandom_range(1, MAXL));
      build_frame(8'($urandom_range(0, 255)), len, ($urandom_range(0, 3) == 0), f);
      kind = model_frame(f);
      if ($urandom_range(0, 1) == 1) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_bytes({g});
      end
      for (int i = 0; i < f.size(); i++) begin
        iData = f[i]; iValid = 1'b1;
        wr_if.iWrReady = 1'($urandom_range(0, 1));
        tick();
        iValid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      k = 0;
      while (oBusy === 1'b1 && k < 300) begin
        wr_if.iWrReady = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      wr_if.iWrReady = 1'b1;
      wait_idle(40);
      tick();
      check_writes("rand");
      check_errs("rand", (kind == 1) ? 1 : 0, (kind == 2) ? 1 : 0, 0, 0);
    end
  endtask

  initial begin
    iRstN = 1'b0; iValid = 1'b0; iData = 8'h00; wr_if.iWrReady = 1'b1;
    test_reset();
    test_good_frame();
    test_csum_err();
    test_addr_wrap();
    test_len_err();
    test_timeout();
    test_overrun_stall();
    test_reset_mid_commit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
